csr_counter_unit: RTL and testbench

Parametrised CSR and performance-counter block for the 3-stage RV32 pipeline. It replaces the single write-only `csr` register with a full CSR unit:
- `tohost` register
- `cycle` and `instret` counters, each `CNT_WIDTH` wide
- `NUM_HPM` event counters

It executes CSRRW/CSRRS/CSRRC issued from X. It returns the old CSR value, registered, for writeback in WB.

---
 rtl/csr_counter_unit_if.sv | 28 ++
 rtl/csr_counter_unit.sv | 125 ++++++++++++
 tb/tb_csr_counter_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_counter_unit_if.sv
// CSR access bus plus pipeline-side strobes connecting the pipeline to csr_counter_unit.
interface csr_counter_unit_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_HPM = 4
);
    logic               stall;
    logic               csr_valid;
    logic [1:0]         csr_op;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata;
    logic               retire;
    logic [NUM_HPM-1:0] hpm_event;
    logic [XLEN-1:0]    csr_rdata;
    logic               csr_illegal;
    logic [XLEN-1:0]    tohost;

    // Pipeline side: issues accesses and event strobes, consumes results.
    modport master (
        output stall, csr_valid, csr_op, csr_addr, csr_wdata, retire, hpm_event,
        input  csr_rdata, csr_illegal, tohost
    );

    // CSR unit side.
    modport slave (
        input  stall, csr_valid, csr_op, csr_addr, csr_wdata, retire, hpm_event,
        output csr_rdata, csr_illegal, tohost
    );
endinterface

// File: rtl/csr_counter_unit.sv
// CSR unit: tohost register, cycle/instret/hpm counters, CSRRW/CSRRS/CSRRC from X with the old
// value returned registered for WB.
module csr_counter_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CNT_WIDTH   = 64,
    parameter int unsigned NUM_HPM     = 4,
    parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
    input logic               clk,
    input logic               reset,
    csr_counter_unit_if.slave bus
);
    // Counter slots: 0 = cycle, 1 = instret, 2+i = hpm[i].
    localparam int unsigned NumCnt = NUM_HPM + 2;
    localparam int unsigned IdxW   = $clog2(NumCnt);

    logic [CNT_WIDTH-1:0] r_cnt [NumCnt];
    logic [XLEN-1:0]      r_tohost;
    logic [XLEN-1:0]      r_rdata;
    logic                 r_illegal;

    logic                 w_acc;
    logic                 w_is_tohost;
    logic                 w_is_cnt;
    logic                 w_ro;
    logic                 w_high;
    logic [IdxW-1:0]      w_sel;
    logic [2*XLEN-1:0]    w_sel_ext;
    logic [XLEN-1:0]      w_old;
    logic [XLEN-1:0]      w_new;
    logic                 w_wr_req;
    logic                 w_illegal;
    logic                 w_wr;
    logic [NumCnt-1:0]    w_inc;
    logic [2*XLEN-1:0]    w_wr_ext;
    logic [CNT_WIDTH-1:0] w_cnt_d [NumCnt];

    // cycle always counts; the others only when the pipeline is moving.
    assign w_inc = {bus.hpm_event & {NUM_HPM{~bus.stall}}, bus.retire & ~bus.stall, 1'b1};

    // Address decode, old-value read and new-value computation.
    always_comb begin
        w_acc       = bus.csr_valid & ~bus.stall & (bus.csr_op != 2'b00);
        w_is_tohost = (bus.csr_addr == TOHOST_ADDR);
        w_ro        = (bus.csr_addr[11:8] == 4'hC);
        w_high      = bus.csr_addr[7];
        w_is_cnt    = 1'b0;
        w_sel       = '0;
        if (!w_is_tohost && (w_ro || bus.csr_addr[11:8] == 4'hB)) begin
            if (bus.csr_addr[6:0] == 7'd0) begin
                w_is_cnt = 1'b1;
            end else if (bus.csr_addr[6:0] >= 7'd2 && bus.csr_addr[6:0] < 7'(NUM_HPM + 3)) begin
                // 0x02 -> instret (slot 1), 0x03+i -> hpm[i] (slot 2+i)
                w_is_cnt = 1'b1;
                w_sel    = IdxW'(bus.csr_addr[6:0] - 7'd1);
            end
        end

        w_sel_ext = (2*XLEN)'(r_cnt[w_sel]);
        if (w_is_tohost) begin
            w_old = r_tohost;
        end else if (w_is_cnt) begin
            w_old = w_high ? w_sel_ext[2*XLEN-1:XLEN] : w_sel_ext[XLEN-1:0];
        end else begin
            w_old = '0;
        end

        unique case (bus.csr_op)
            2'b01:   w_new = bus.csr_wdata;
            2'b10:   w_new = w_old | bus.csr_wdata;
            2'b11:   w_new = w_old & ~bus.csr_wdata;
            default: w_new = w_old;
        endcase

        w_wr_req  = (bus.csr_op == 2'b01) || (bus.csr_wdata != '0);
        w_illegal = (!w_is_tohost && !w_is_cnt) || (w_is_cnt && w_ro && w_wr_req);
        w_wr      = w_acc && !w_illegal && w_wr_req;
    end

    // Counter next state: a write replaces one half and drops that counter's increment.
    always_comb begin
        w_wr_ext = '0;
        for (int i = 0; i < NumCnt; i++) begin
            w_cnt_d[i] = r_cnt[i] + CNT_WIDTH'(w_inc[i]);
            if (w_wr && w_is_cnt && (w_sel == IdxW'(i))) begin
                w_wr_ext = (2*XLEN)'(r_cnt[i]);
                if (w_high) begin
                    w_wr_ext[2*XLEN-1:XLEN] = w_new;
                end else begin
                    w_wr_ext[XLEN-1:0] = w_new;
                end
                w_cnt_d[i] = w_wr_ext[CNT_WIDTH-1:0];
            end
        end
    end

    // State update; read result holds across stalls and idle cycles, illegal flag pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumCnt; i++) begin
                r_cnt[i] <= '0;
            end
            r_tohost  <= '0;
            r_rdata   <= '0;
            r_illegal <= 1'b0;
        end else begin
            for (int i = 0; i < NumCnt; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
            if (w_wr && w_is_tohost) begin
                r_tohost <= w_new;
            end
            if (w_acc) begin
                r_rdata   <= w_illegal ? '0 : w_old;
                r_illegal <= w_illegal;
            end else if (!bus.stall) begin
                r_illegal <= 1'b0;
            end
        end
    end

    assign bus.csr_rdata   = r_rdata;
    assign bus.csr_illegal = r_illegal;
    assign bus.tohost      = r_tohost;
endmodule

// File: tb/tb_csr_counter_unit.sv
// Self-checking bench for csr_counter_unit: directed test-plan steps, a random phase and a
// mid-access reset, all compared against a 64-bit arithmetic model of the CSR file.
module tb_csr_counter_unit;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    csr_counter_unit_if #(.XLEN(32), .NUM_HPM(4)) bus ();

    csr_counter_unit #(
        .XLEN       (32),
        .CNT_WIDTH  (64),
        .NUM_HPM    (4),
        .TOHOST_ADDR(12'h51E)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: counters as plain 64-bit numbers (0 cycle, 1 instret, 2+i hpm[i]).
    logic [63:0] m_cnt [6];
    logic [31:0] m_tohost;
    logic [31:0] m_rdata;
    logic        m_illegal;

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_cnt[i] = 64'd0;
        m_tohost  = 32'd0;
        m_rdata   = 32'd0;
        m_illegal = 1'b0;
    endtask

    // Applies one rising edge worth of behaviour using the inputs currently on the bus.
    task automatic model_edge();
        int          num [6] = '{0, 2, 3, 4, 5, 6};
        logic [63:0] nxt [6];
        bit          acc, th, mapped, hi, ro, wreq, ill;
        int          k;
        logic [31:0] old, nv;
        th     = (bus.csr_addr == 12'h51E);
        mapped = th;
        k      = -1;
        hi     = 1'b0;
        ro     = 1'b0;
        for (int c = 0; c < 6; c++) begin
            for (int h = 0; h < 2; h++) begin
                for (int p = 0; p < 2; p++) begin
                    if (bus.csr_addr == (p == 1 ? 12'hC00 : 12'hB00) + 12'(h * 128 + num[c])) begin
                        mapped = 1'b1;
                        k      = c;
                        hi     = (h == 1);
                        ro     = (p == 1);
                    end
                end
            end
        end
        if (th) old = m_tohost;
        else if (k >= 0) old = hi ? m_cnt[k][63:32] : m_cnt[k][31:0];
        else old = 32'd0;
        case (bus.csr_op)
            2'd1:    nv = bus.csr_wdata;
            2'd2:    nv = old | bus.csr_wdata;
            2'd3:    nv = old & ~bus.csr_wdata;
            default: nv = old;
        endcase
        wreq = (bus.csr_op == 2'd1) || (bus.csr_wdata != 32'd0);
        ill  = !mapped || (ro && wreq);
        acc  = bus.csr_valid && !bus.stall && (bus.csr_op != 2'd0);

        nxt[0] = m_cnt[0] + 64'd1;
        nxt[1] = m_cnt[1] + ((bus.retire && !bus.stall) ? 64'd1 : 64'd0);
        for (int i = 0; i < 4; i++)
            nxt[2+i] = m_cnt[2+i] + ((bus.hpm_event[i] && !bus.stall) ? 64'd1 : 64'd0);
        if (acc && !ill && wreq) begin
            if (th) m_tohost = nv;
            else if (hi) nxt[k] = {nv, m_cnt[k][31:0]};
            else nxt[k] = {m_cnt[k][63:32], nv};
        end
        for (int i = 0; i < 6; i++) m_cnt[i] = nxt[i];
        if (acc) begin
            m_rdata   = ill ? 32'd0 : old;
            m_illegal = ill;
        end else if (!bus.stall) begin
            m_illegal = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check("rdata", bus.csr_rdata, m_rdata);
        check("illegal", 32'(bus.csr_illegal), 32'(m_illegal));
        check("tohost", bus.tohost, m_tohost);
    endtask

    // Drives one cycle of inputs, waits for the edge, then checks against the model.
    task automatic step(input bit v, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input bit st, input bit rt, input logic [3:0] ev);
        bus.csr_valid = v;
        bus.csr_op    = op;
        bus.csr_addr  = a;
        bus.csr_wdata = wd;
        bus.stall     = st;
        bus.retire    = rt;
        bus.hpm_event = ev;
        @(posedge clk);
        #1;
        model_edge();
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 12'h000, 32'd0, 1'b0, 1'b0, 4'd0);
    endtask

    logic [11:0] pool [16] = '{12'h51E, 12'hC00, 12'hB00, 12'hC80, 12'hB80, 12'hC02, 12'hB02,
                               12'hC82, 12'hB82, 12'hC03, 12'hB05, 12'hB86, 12'hC06, 12'hC01,
                               12'hC07, 12'h7FF};

    initial begin
        logic [31:0] wd;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.csr_valid = 1'b0;
        bus.csr_op    = 2'd0;
        bus.csr_addr  = 12'h000;
        bus.csr_wdata = 32'd0;
        bus.stall     = 1'b0;
        bus.retire    = 1'b0;
        bus.hpm_event = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", bus.csr_rdata, 32'd0);
        check("reset_illegal", 32'(bus.csr_illegal), 32'd0);
        check("reset_tohost", bus.tohost, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Cycle counter after 10 idle cycles.
        idle(10);
        step(1'b1, 2'd2, 12'hC00, 32'd0, 1'b0, 1'b0, 4'd0);
        check("cycle_after_10", bus.csr_rdata, 32'd10);
        check("cycle_read_legal", 32'(bus.csr_illegal), 32'd0);

        // tohost write then clear-bits.
        step(1'b1, 2'd1, 12'h51E, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0);
        check("tohost_rw_old", bus.csr_rdata, 32'd0);
        check("tohost_rw_val", bus.tohost, 32'hDEADBEEF);
        step(1'b1, 2'd3, 12'h51E, 32'h0000FFFF, 1'b0, 1'b0, 4'd0);
        check("tohost_rc_old", bus.csr_rdata, 32'hDEADBEEF);
        check("tohost_rc_val", bus.tohost, 32'hDEAD0000);

        // cycle low write to all ones, then carry into the high half.
        step(1'b1, 2'd1, 12'hB00, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd0);
        idle(2);
        step(1'b1, 2'd2, 12'hC00, 32'd0, 1'b0, 1'b0, 4'd0);
        check("cycle_lo_wrap", bus.csr_rdata, 32'd1);
        step(1'b1, 2'd2, 12'hC80, 32'd0, 1'b0, 1'b0, 4'd0);
        check("cycle_hi_carry", bus.csr_rdata, 32'd1);

        // instret with two stalled retire cycles; a stalled write is ignored.
        step(1'b0, 2'd0, 12'h000, 32'd0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 2'd0, 12'h000, 32'd0, 1'b1, 1'b1, 4'd0);
        step(1'b0, 2'd0, 12'h000, 32'd0, 1'b0, 1'b1, 4'd0);
        step(1'b1, 2'd1, 12'hB02, 32'h55, 1'b1, 1'b1, 4'd0);
        check("stall_rdata_hold", bus.csr_rdata, 32'd1);
        step(1'b0, 2'd0, 12'h000, 32'd0, 1'b0, 1'b1, 4'd0);
        step(1'b1, 2'd2, 12'hC02, 32'd0, 1'b0, 1'b0, 4'd0);
        check("instret_3", bus.csr_rdata, 32'd3);

        // Read-only write, read-only plain read, unmapped address.
        step(1'b1, 2'd1, 12'hC02, 32'd5, 1'b0, 1'b0, 4'd0);
        check("ro_write_illegal", 32'(bus.csr_illegal), 32'd1);
        check("ro_write_rdata", bus.csr_rdata, 32'd0);
        step(1'b1, 2'd2, 12'hC02, 32'd0, 1'b0, 1'b0, 4'd0);
        check("ro_read_legal", 32'(bus.csr_illegal), 32'd0);
        check("instret_unchanged", bus.csr_rdata, 32'd3);
        step(1'b1, 2'd2, 12'h7FF, 32'd0, 1'b0, 1'b0, 4'd0);
        check("unmapped_illegal", 32'(bus.csr_illegal), 32'd1);
        check("unmapped_rdata", bus.csr_rdata, 32'd0);
        idle(1);
        check("illegal_clears", 32'(bus.csr_illegal), 32'd0);

        // hpm[1]: 7 pulses, write of 100 lands on the 4th (that pulse is dropped).
        for (int i = 0; i < 7; i++) begin
            if (i == 3) step(1'b1, 2'd1, 12'hB04, 32'd100, 1'b0, 1'b0, 4'b0010);
            else step(1'b0, 2'd0, 12'h000, 32'd0, 1'b0, 1'b0, 4'b0010);
        end
        step(1'b1, 2'd2, 12'hC04, 32'd0, 1'b0, 1'b0, 4'd0);
        check("hpm1_value", bus.csr_rdata, 32'd103);

        // Random phase against the model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       wd = 32'd0;
                1:       wd = 32'hFFFFFFFF;
                default: wd = $urandom;
            endcase
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 pool[$urandom_range(0, 15)], wd, ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        // Reset asserted in the middle of a tohost write: outputs clear at once, write lost.
        bus.csr_valid = 1'b1;
        bus.csr_op    = 2'd1;
        bus.csr_addr  = 12'h51E;
        bus.csr_wdata = 32'h12345678;
        bus.stall     = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("midreset_rdata", bus.csr_rdata, 32'd0);
        check("midreset_illegal", 32'(bus.csr_illegal), 32'd0);
        check("midreset_tohost", bus.tohost, 32'd0);
        model_reset();
        @(posedge clk);
        bus.csr_valid = 1'b0;
        bus.csr_op    = 2'd0;
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        check("post_reset_tohost", bus.tohost, 32'd0);
        step(1'b1, 2'd2, 12'hC00, 32'd0, 1'b0, 1'b0, 4'd0);
        check("post_reset_cycle", bus.csr_rdata, 32'd4);
        step(1'b1, 2'd2, 12'hC80, 32'd0, 1'b0, 1'b0, 4'd0);
        check("post_reset_cycle_hi", bus.csr_rdata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
